// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// and the MEM stage. Each access is issued from IDLE, then waits LAT-1
// cycles in WAIT and completes with a one-cycle valid pulse.
// The issue and completion cycles are decided combinationally so the
// memory strobe and returned data line up with the macro's timing.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to let fetch win after
// STARVE_MAX consecutive data grants that were issued while fetch was waiting.

module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_valid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_valid,
  output logic             stall_F,
  output logic             stall_MEM,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Wait-cycle preset: the completion cycle is the one where the count is zero.
  localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       owner_d_r;   // 1 = data port owns the access in flight
  logic       owner_we_r;  // access in flight is a store
  logic       grant_d_s;
  logic       grant_f_s;
  logic       starve_hit_s;
  logic       issue_s;
  logic       done_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_r;

  assign starve_hit_s = ({29'd0, starve_r} >= 32'(STARVE_MAX));

  // Count data grants taken while fetch waits; any fetch grant clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_r <= 3'd0;
    end else if (issue_s && grant_f_s) begin
      starve_r <= 3'd0;
    end else if (issue_s && grant_d_s && if_req && (starve_r != 3'd7)) begin
      starve_r <= starve_r + 3'd1;
    end else begin
      starve_r <= starve_r;
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  // Pick a winner: data is older in the pipeline, unless fetch is being starved.
  always_comb begin
    grant_d_s = 1'b0;
    grant_f_s = 1'b0;
    if (d_req && if_req) begin
      if (starve_hit_s) begin
        grant_f_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else if (if_req) begin
      grant_f_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
      grant_f_s = 1'b0;
    end
  end

  // Reset gates the issue so the memory sees no strobe while rst is low.
  assign issue_s = rst && (state_r == IDLE) && (d_req || if_req);
  assign done_s  = (state_r == WAIT) && (cnt_r == 3'd0);

  // Drive the memory port with the winner's request in the issue cycle only.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_s) begin
      mem_en = 1'b1;
      if (grant_d_s) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else begin
        mem_we    = 1'b0;
        mem_addr  = if_addr;
        mem_wdata = '0;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Completion: pulse the owner's valid and pass memory data straight through.
  always_comb begin
    if_valid = done_s && !owner_d_r;
    d_valid  = done_s && owner_d_r;
    if_rdata = '0;
    d_rdata  = '0;
    if (if_valid) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = '0;
    end
    if (d_valid && !owner_we_r) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = '0;
    end
  end

  assign stall_F   = if_req & ~if_valid;
  assign stall_MEM = d_req & ~d_valid;

  // Access sequencer: latch the owner at issue, count down, return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      owner_d_r  <= 1'b0;
      owner_we_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            owner_d_r  <= grant_d_s;
            owner_we_r <= grant_d_s & d_we;
            cnt_r      <= LAT_M1;
            state_r    <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_r == 3'd0) begin
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one LAT=2 instance (a_*) and one
// LAT=1 instance (b_*) sharing clock and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          fails = 0;

  logic        a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_if_valid, a_d_valid, a_stall_F, a_stall_MEM, a_mem_en, a_mem_we;

  logic        b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_valid, b_d_valid, b_stall_F, b_stall_MEM, b_mem_en, b_mem_we;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_valid(a_d_valid),
    .stall_F(a_stall_F), .stall_MEM(a_stall_MEM),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.WIDTH(32), .LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid),
    .stall_F(b_stall_F), .stall_MEM(b_stall_MEM),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_if_req = 1'b1; a_if_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = 32'h0; a_d_wdata = 32'h0; a_mem_rdata = 32'hFFFF_FFFF;
    b_if_req = 1'b0; b_if_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'h0; b_d_wdata = 32'h0; b_mem_rdata = 32'h0;

    // Reset: outputs quiet, stall_F follows if_req
    #3;
    chk("rst_mem_en",   {31'd0, a_mem_en},   32'd0);
    chk("rst_mem_addr", a_mem_addr,          32'd0);
    chk("rst_if_valid", {31'd0, a_if_valid}, 32'd0);
    chk("rst_if_rdata", a_if_rdata,          32'd0);
    chk("rst_stall_F",  {31'd0, a_stall_F},  32'd1);

    // Release with no request: idle
    cyc();
    a_if_req = 1'b0; rst = 1'b1; #1;
    chk("idle_mem_en", {31'd0, a_mem_en}, 32'd0);

    // Single fetch 0x40
    cyc();
    a_if_req = 1'b1; a_if_addr = 32'h40; #1;
    chk("f_T_mem_en",   {31'd0, a_mem_en},  32'd1);
    chk("f_T_mem_addr", a_mem_addr,         32'h40);
    chk("f_T_mem_we",   {31'd0, a_mem_we},  32'd0);
    chk("f_T_stall_F",  {31'd0, a_stall_F}, 32'd1);
    cyc(); #1;
    chk("f_T1_mem_en",   {31'd0, a_mem_en},   32'd0);
    chk("f_T1_if_valid", {31'd0, a_if_valid}, 32'd0);
    chk("f_T1_stall_F",  {31'd0, a_stall_F},  32'd1);
    cyc();
    a_mem_rdata = 32'h0050_0093; #1;
    chk("f_T2_if_valid", {31'd0, a_if_valid}, 32'd1);
    chk("f_T2_if_rdata", a_if_rdata,          32'h0050_0093);
    chk("f_T2_stall_F",  {31'd0, a_stall_F},  32'd0);
    chk("f_T2_d_valid",  {31'd0, a_d_valid},  32'd0);
    cyc();
    a_if_req = 1'b0; #1;
    chk("f_T3_if_valid", {31'd0, a_if_valid}, 32'd0);
    chk("f_T3_if_rdata", a_if_rdata,          32'd0);

    // Simultaneous load 0x100 and fetch 0x44: data first
    cyc();
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h100;
    a_if_req = 1'b1; a_if_addr = 32'h44; #1;
    chk("s_T_mem_en",    {31'd0, a_mem_en},    32'd1);
    chk("s_T_mem_addr",  a_mem_addr,           32'h100);
    chk("s_T_stall_MEM", {31'd0, a_stall_MEM}, 32'd1);
    cyc(); #1;
    chk("s_T1_mem_en", {31'd0, a_mem_en}, 32'd0);
    cyc();
    a_mem_rdata = 32'h1111_2222; #1;
    chk("s_T2_d_valid",   {31'd0, a_d_valid},   32'd1);
    chk("s_T2_d_rdata",   a_d_rdata,            32'h1111_2222);
    chk("s_T2_if_valid",  {31'd0, a_if_valid},  32'd0);
    chk("s_T2_if_rdata",  a_if_rdata,           32'd0);
    chk("s_T2_stall_MEM", {31'd0, a_stall_MEM}, 32'd0);
    chk("s_T2_stall_F",   {31'd0, a_stall_F},   32'd1);
    cyc();
    a_d_req = 1'b0; #1;
    chk("s_T3_mem_en",   {31'd0, a_mem_en},  32'd1);
    chk("s_T3_mem_addr", a_mem_addr,         32'h44);
    chk("s_T3_d_valid",  {31'd0, a_d_valid}, 32'd0);
    cyc(); #1;
    chk("s_T4_if_valid", {31'd0, a_if_valid}, 32'd0);
    cyc();
    a_mem_rdata = 32'h2222_3333; #1;
    chk("s_T5_if_valid", {31'd0, a_if_valid}, 32'd1);
    chk("s_T5_if_rdata", a_if_rdata,          32'h2222_3333);
    chk("s_T5_d_rdata",  a_d_rdata,           32'd0);
    cyc();
    a_if_req = 1'b0; #1;

    // Store 0x200 <- 0xDEADBEEF
    cyc();
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h200; a_d_wdata = 32'hDEAD_BEEF; #1;
    chk("w_T_mem_en",    {31'd0, a_mem_en}, 32'd1);
    chk("w_T_mem_we",    {31'd0, a_mem_we}, 32'd1);
    chk("w_T_mem_addr",  a_mem_addr,        32'h200);
    chk("w_T_mem_wdata", a_mem_wdata,       32'hDEAD_BEEF);
    cyc(); #1;
    cyc();
    a_mem_rdata = 32'h5555_5555; #1;
    chk("w_T2_d_valid", {31'd0, a_d_valid}, 32'd1);
    chk("w_T2_d_rdata", a_d_rdata,          32'd0);
    cyc();
    a_d_req = 1'b0; a_d_we = 1'b0; #1;

    // Reset asserted in WAIT aborts the fetch
    cyc();
    a_if_req = 1'b1; a_if_addr = 32'h80; #1;
    chk("r_T_mem_en", {31'd0, a_mem_en}, 32'd1);
    cyc();
    rst = 1'b0; #1;
    chk("r_T1_mem_en",   {31'd0, a_mem_en},   32'd0);
    chk("r_T1_mem_addr", a_mem_addr,          32'd0);
    chk("r_T1_if_valid", {31'd0, a_if_valid}, 32'd0);
    cyc();
    a_mem_rdata = 32'h9999_9999; #1;
    chk("r_T2_if_valid", {31'd0, a_if_valid}, 32'd0);
    chk("r_T2_if_rdata", a_if_rdata,          32'd0);
    cyc();
    rst = 1'b1; a_if_addr = 32'h84; #1;
    chk("r_T3_mem_en",   {31'd0, a_mem_en}, 32'd1);
    chk("r_T3_mem_addr", a_mem_addr,        32'h84);
    cyc(); #1;
    chk("r_T4_if_valid", {31'd0, a_if_valid}, 32'd0);
    cyc();
    a_mem_rdata = 32'h0000_0084; #1;
    chk("r_T5_if_valid", {31'd0, a_if_valid}, 32'd1);
    chk("r_T5_if_rdata", a_if_rdata,          32'h0000_0084);
    cyc();
    a_if_req = 1'b0; #1;

    // Both held continuously: grant order
    cyc();
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h300;
    a_if_req = 1'b1; a_if_addr = 32'h90;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_addr;
      logic        exp_fetch;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_fetch = (i == 4);
`else
      exp_fetch = 1'b0;
`endif
      exp_addr = exp_fetch ? 32'h90 : 32'h300;
      #1;
      chk("sv_mem_en",   {31'd0, a_mem_en}, 32'd1);
      chk("sv_mem_addr", a_mem_addr,        exp_addr);
      cyc(); #1;
      cyc(); #1;
      chk("sv_if_valid", {31'd0, a_if_valid}, {31'd0, exp_fetch});
      chk("sv_d_valid",  {31'd0, a_d_valid},  {31'd0, ~exp_fetch});
      cyc();
    end
    a_d_req = 1'b0; a_if_req = 1'b0;

    // LAT=1 back-to-back fetches 0x0 then 0x4
    cyc();
    b_if_req = 1'b1; b_if_addr = 32'h0; #1;
    chk("l1_T_mem_en",   {31'd0, b_mem_en}, 32'd1);
    chk("l1_T_mem_addr", b_mem_addr,        32'h0);
    cyc();
    b_mem_rdata = 32'hAAAA_0000; #1;
    chk("l1_T1_if_valid", {31'd0, b_if_valid}, 32'd1);
    chk("l1_T1_if_rdata", b_if_rdata,          32'hAAAA_0000);
    chk("l1_T1_mem_en",   {31'd0, b_mem_en},   32'd0);
    cyc();
    b_if_addr = 32'h4; #1;
    chk("l1_T2_mem_en",   {31'd0, b_mem_en},   32'd1);
    chk("l1_T2_mem_addr", b_mem_addr,          32'h4);
    chk("l1_T2_if_valid", {31'd0, b_if_valid}, 32'd0);
    cyc();
    b_mem_rdata = 32'hAAAA_0004; #1;
    chk("l1_T3_if_valid", {31'd0, b_if_valid}, 32'd1);
    chk("l1_T3_if_rdata", b_if_rdata,          32'hAAAA_0004);
    cyc();
    b_if_req = 1'b0; #1;
    chk("l1_T4_mem_en", {31'd0, b_mem_en}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
